// File: rtl/div_pkg.sv
// Shared types and helpers for the shift-subtract divider (and the signed multiplier path).
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int unsigned MAX_NUM_BITS = 64;
    // Sized for the widest legal operand so one counter type serves every NUM_BITS.
    localparam int unsigned CNT_W        = $clog2(MAX_NUM_BITS) + 1;

    function automatic logic [MAX_NUM_BITS-1:0] twos_neg(input logic [MAX_NUM_BITS-1:0] x);
        return ~x + MAX_NUM_BITS'(1);
    endfunction

endpackage

// File: rtl/restoring_sub_stage.sv
// One restoring step: subtract divisor from the shifted partial remainder via a
// ripple full-adder chain (inverted divisor, carry-in 1); restore when it borrows.
module restoring_sub_stage #(
    parameter int unsigned NUM_BITS = 32
) (
    input  logic [NUM_BITS:0]   rem_shifted,
    input  logic [NUM_BITS-1:0] divisor,
    output logic [NUM_BITS-1:0] next_rem,
    output logic                q_bit
);

    logic [NUM_BITS:0]   carry;
    logic [NUM_BITS-1:0] diff;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < NUM_BITS; i++) begin : g_fa
        logic b_inv;
        assign b_inv        = ~divisor[i];
        assign diff[i]      = rem_shifted[i] ^ b_inv ^ carry[i];
        assign carry[i+1]   = (rem_shifted[i] & b_inv) | (rem_shifted[i] & carry[i]) | (b_inv & carry[i]);
    end

    // Top bit sees an inverted zero (=1); carry-out of that cell means no borrow.
    assign q_bit    = rem_shifted[NUM_BITS] | carry[NUM_BITS];
    assign next_rem = q_bit ? diff : rem_shifted[NUM_BITS-1:0];

endmodule

// File: rtl/shift_sub_seq_divider.sv
// Radix-2 restoring sequential divider, one quotient bit per clock, fixed latency.
// Define SIGNED_DIV_EN to add the sign_op input for two's-complement truncating division.
module shift_sub_seq_divider
    import div_pkg::*;
#(
    parameter int unsigned NUM_BITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef SIGNED_DIV_EN
    input  logic                sign_op,
`endif
    input  logic [NUM_BITS-1:0] dividend,
    input  logic [NUM_BITS-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] quotient,
    output logic [NUM_BITS-1:0] remainder,
    output logic                div_by_zero
);

    div_state_t          state_q;
    logic [CNT_W-1:0]    count_q;
    logic [NUM_BITS-1:0] rem_q, qreg_q, dreg_q;
    logic [NUM_BITS-1:0] quotient_q, remainder_q;
    logic                busy_q, done_q, dbz_q;

    logic [NUM_BITS:0]   rem_shifted;
    logic [NUM_BITS-1:0] next_rem, q_next;
    logic                q_bit;
    logic [NUM_BITS-1:0] mag_a, mag_b, q_fin, r_fin, dbz_rem;

    function automatic logic [NUM_BITS-1:0] neg_n(input logic [NUM_BITS-1:0] x);
        return NUM_BITS'(twos_neg(MAX_NUM_BITS'(x)));
    endfunction

    assign rem_shifted = {rem_q, qreg_q[NUM_BITS-1]};
    assign q_next      = {qreg_q[NUM_BITS-2:0], q_bit};

    restoring_sub_stage #(.NUM_BITS(NUM_BITS)) u_stage (
        .rem_shifted (rem_shifted),
        .divisor     (dreg_q),
        .next_rem    (next_rem),
        .q_bit       (q_bit)
    );

`ifdef SIGNED_DIV_EN
    logic sign_a_q, sign_b_q;
    logic neg_a, neg_b;

    // Operand magnitudes on entry; sign restoration on exit (truncating division).
    always_comb begin
        neg_a   = sign_op & dividend[NUM_BITS-1];
        neg_b   = sign_op & divisor[NUM_BITS-1];
        mag_a   = neg_a ? neg_n(dividend) : dividend;
        mag_b   = neg_b ? neg_n(divisor) : divisor;
        q_fin   = (sign_a_q ^ sign_b_q) ? neg_n(q_next) : q_next;
        r_fin   = sign_a_q ? neg_n(next_rem) : next_rem;
        dbz_rem = sign_a_q ? neg_n(qreg_q) : qreg_q;
    end
`else
    always_comb begin
        mag_a   = dividend;
        mag_b   = divisor;
        q_fin   = q_next;
        r_fin   = next_rem;
        dbz_rem = qreg_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            qreg_q      <= '0;
            dreg_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= LOAD;
                        busy_q   <= 1'b1;
                        dbz_q    <= 1'b0;
                        rem_q    <= '0;
                        count_q  <= '0;
                        qreg_q   <= mag_a;
                        dreg_q   <= mag_b;
`ifdef SIGNED_DIV_EN
                        sign_a_q <= neg_a;
                        sign_b_q <= neg_b;
`endif
                    end
                end
                LOAD: begin
                    if (dreg_q == '0) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        dbz_q       <= 1'b1;
                        quotient_q  <= '1;
                        remainder_q <= dbz_rem;
                    end else begin
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    rem_q   <= next_rem;
                    qreg_q  <= q_next;
                    count_q <= count_q + CNT_W'(1);
                    // Results are registered on the last step so they coincide with done.
                    if (count_q == CNT_W'(NUM_BITS - 1)) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= q_fin;
                        remainder_q <= r_fin;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
